// File: rtl/menu_pkg.sv
// Shared constants for the menu button pixel generator: colours, ROM colour
// codes and the per-button state type.
package menu_pkg;

    typedef enum logic [1:0] {
        BTN_IDLE,
        BTN_HOVER,
        BTN_PRESS,
        BTN_FLASH
    } btn_state_e;

    // RGB444 colours
    localparam logic [11:0] COL_WHITE      = 12'hFFF;
    localparam logic [11:0] COL_BLACK      = 12'h000;
    localparam logic [11:0] COL_LINK_UP    = 12'h567;
    localparam logic [11:0] COL_LINK_DOWN  = 12'h123;
    localparam logic [11:0] COL_BTN_IDLE   = 12'h000;
    localparam logic [11:0] COL_BTN_HOVER  = 12'h32E;
    localparam logic [11:0] COL_BTN_ACTIVE = 12'h3E2;

    // ROM colour codes; button k is drawn with code CODE_BTN_BASE + k
    localparam logic [3:0] CODE_WHITE    = 4'd0;
    localparam logic [3:0] CODE_BLACK    = 4'd1;
    localparam logic [3:0] CODE_LINK     = 4'd3;
    localparam int         CODE_BTN_BASE = 4;

    // Colour a button is painted with in a given state
    function automatic logic [11:0] btn_colour(input btn_state_e s);
        case (s)
            BTN_HOVER:           return COL_BTN_HOVER;
            BTN_PRESS, BTN_FLASH: return COL_BTN_ACTIVE;
            default:             return COL_BTN_IDLE;
        endcase
    endfunction

endpackage

// File: rtl/menu_button_pixel_gen_if.sv
// ROM read bus between the pixel generator (master) and the external image ROM.
interface menu_button_pixel_gen_if;
    logic [16:0] rom_addr;
    logic [3:0]  rom_data;

    modport master (output rom_addr, input rom_data);
    modport slave  (input rom_addr, output rom_data);
endinterface

// File: rtl/menu_btn_fsm.sv
// One menu button: hover/press/click tracking plus the post-click flash timer.
module menu_btn_fsm
    import menu_pkg::*;
#(
    parameter int FLASH_CYC = 8
) (
    input  logic        clka,
    input  logic        rst,
    input  logic        hover,
    input  logic        press_edge,
    input  logic        mouse_left,
    output logic        click,
    output logic [11:0] colour
);

    localparam int CW = (FLASH_CYC > 1) ? $clog2(FLASH_CYC) : 1;

    btn_state_e    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          click_d;

    // State, flash counter and registered click pulse
    always_ff @(posedge clka) begin
        // NOTE: state is updated with non-blocking assignments so every
        // register samples the pre-edge values of its neighbours.
        if (rst) begin
            state_q <= BTN_IDLE;
            cnt_q   <= '0;
            click   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            click   <= click_d;
        end
    end

    // Next-state decode; a release over the button is the click, leaving
    // the button while held cancels it
    always_comb begin
        // NOTE: every output gets a default first so no path infers a latch.
        state_d = state_q;
        cnt_d   = cnt_q;
        click_d = 1'b0;
        case (state_q)
            BTN_IDLE: begin
                if (hover) state_d = BTN_HOVER;
            end
            BTN_HOVER: begin
                if (!hover)          state_d = BTN_IDLE;
                else if (press_edge) state_d = BTN_PRESS;
            end
            BTN_PRESS: begin
                if (!hover) begin
                    state_d = BTN_IDLE;
                end else if (!mouse_left) begin
                    state_d = BTN_FLASH;
                    cnt_d   = CW'(FLASH_CYC - 1);
                    click_d = 1'b1;
                end
            end
            BTN_FLASH: begin
                if (cnt_q == '0) state_d = hover ? BTN_HOVER : BTN_IDLE;
                else             cnt_d   = cnt_q - 1'b1;
            end
            default: state_d = BTN_IDLE;
        endcase
    end

    assign colour = btn_colour(state_q);

endmodule

// File: rtl/menu_button_pixel_gen.sv
// Menu screen pixel generator: addresses the external image ROM from the
// video counters, maps ROM colour codes to RGB444 and recolours buttons
// according to mouse interaction.
module menu_button_pixel_gen
    import menu_pkg::*;
#(
    parameter int N_BTN     = 4,
    parameter int SCALE     = 1,
    parameter int IMG_W     = 320,
    parameter int DEPTH     = 76800,
    parameter int ROM_LAT   = 1,
    parameter int FLASH_CYC = 8
) (
    input  logic                    clka,
    input  logic                    rst,
    input  logic [9:0]              h_cnt,
    input  logic [9:0]              v_cnt,
    input  logic                    valid,
    input  logic                    mouse_left,
    input  logic                    mouse_on_btn,
    input  logic [3:0]              mouse_btn_id,
    input  logic                    connected,
    menu_button_pixel_gen_if.master rom,
    output logic [11:0]             pixel_out,
    output logic [N_BTN-1:0]        btn_click
);

    logic [31:0]      addr_lin;
    logic [16:0]      addr_next;
    logic [ROM_LAT:0] valid_pipe;
    logic             mouse_left_q;
    logic             press_edge;
    logic [N_BTN-1:0] hover;
    logic [11:0]      btn_col [N_BTN];
    logic [11:0]      code_colour;

    // Linear ROM address of the down-scaled pixel, wrapped to the ROM size
    always_comb begin
        addr_lin  = 32'(h_cnt >> SCALE) + 32'(IMG_W) * 32'(v_cnt >> SCALE);
        addr_next = 17'(addr_lin % 32'(DEPTH));
    end

    // Address register, valid delay line (aligns with rom_data) and mouse history
    always_ff @(posedge clka) begin
        if (rst) begin
            rom.rom_addr <= '0;
            valid_pipe   <= '0;
            mouse_left_q <= 1'b1;
        end else begin
            rom.rom_addr  <= addr_next;
            valid_pipe[0] <= valid;
            for (int i = 1; i <= ROM_LAT; i++) valid_pipe[i] <= valid_pipe[i-1];
            mouse_left_q  <= mouse_left;
        end
    end

    // mouse_left_q resets high so a button already held at reset never arms
    assign press_edge = mouse_left && !mouse_left_q;

    // Decode which button the cursor is over; out-of-range ids hover nothing
    always_comb begin
        hover = '0;
        for (int k = 0; k < N_BTN; k++) hover[k] = mouse_on_btn && (mouse_btn_id == 4'(k));
    end

    generate
        for (genvar k = 0; k < N_BTN; k++) begin : g_btn
            menu_btn_fsm #(.FLASH_CYC(FLASH_CYC)) u_fsm (
                .clka       (clka),
                .rst        (rst),
                .hover      (hover[k]),
                .press_edge (press_edge),
                .mouse_left (mouse_left),
                .click      (btn_click[k]),
                .colour     (btn_col[k])
            );
        end
    endgenerate

    // Map the ROM colour code to RGB444, buttons use their live state colour
    always_comb begin
        code_colour = COL_BLACK;
        case (rom.rom_data)
            CODE_WHITE: code_colour = COL_WHITE;
            CODE_BLACK: code_colour = COL_BLACK;
            CODE_LINK:  code_colour = connected ? COL_LINK_UP : COL_LINK_DOWN;
            default: begin
                for (int k = 0; k < N_BTN; k++)
                    if (rom.rom_data == 4'(CODE_BTN_BASE + k)) code_colour = btn_col[k];
            end
        endcase
    end

    // Output pixel register, blanked outside active video
    always_ff @(posedge clka) begin
        if (rst) pixel_out <= COL_BLACK;
        else     pixel_out <= valid_pipe[ROM_LAT] ? code_colour : COL_BLACK;
    end

endmodule

// File: tb/tb_menu_button_pixel_gen.sv
// Self-checking bench for menu_button_pixel_gen: directed mouse scenarios
// plus a randomized run against a cycle-level behavioural model.
module tb_menu_button_pixel_gen;

    localparam int N_BTN     = 4;
    localparam int SCALE     = 1;
    localparam int IMG_W     = 320;
    localparam int DEPTH     = 76800;
    localparam int ROM_LAT   = 1;
    localparam int FLASH_CYC = 8;

    logic             clka = 1'b0;
    logic             rst;
    logic [9:0]       h_cnt, v_cnt;
    logic             valid, mouse_left, mouse_on_btn, connected;
    logic [3:0]       mouse_btn_id;
    logic [11:0]      pixel_out;
    logic [N_BTN-1:0] btn_click;

    int n_cmp = 0;
    int n_bad = 0;

    menu_button_pixel_gen_if rom_bus ();

    menu_button_pixel_gen #(
        .N_BTN(N_BTN), .SCALE(SCALE), .IMG_W(IMG_W), .DEPTH(DEPTH),
        .ROM_LAT(ROM_LAT), .FLASH_CYC(FLASH_CYC)
    ) dut (
        .clka         (clka),
        .rst          (rst),
        .h_cnt        (h_cnt),
        .v_cnt        (v_cnt),
        .valid        (valid),
        .mouse_left   (mouse_left),
        .mouse_on_btn (mouse_on_btn),
        .mouse_btn_id (mouse_btn_id),
        .connected    (connected),
        .rom          (rom_bus.master),
        .pixel_out    (pixel_out),
        .btn_click    (btn_click)
    );

    always #5 clka = ~clka;

    // Image ROM: fixed code when force_code >= 0, otherwise a hash of the address
    int force_code = -1;

    function automatic int rom_fn(input int a);
        if (force_code >= 0) return force_code;
        return (a ^ (a >> 3) ^ (a >> 9)) & 15;
    endfunction

    always @(posedge clka) rom_bus.rom_data <= 4'(rom_fn(int'(rom_bus.rom_addr)));

    // Behavioural model: phase 0 idle, 1 hovered, 2 held, 3 flashing
    int               m_addr = 0, m_rom = 0;
    logic [11:0]      m_pix = 12'h000;
    bit               m_v [ROM_LAT+1];
    bit               m_mlq = 1'b1;
    int               m_ph [N_BTN];
    int               m_fl [N_BTN];
    logic [N_BTN-1:0] m_click = '0;

    function automatic logic [11:0] m_btn_col(input int ph);
        if (ph == 0) return 12'h000;
        if (ph == 1) return 12'h32E;
        return 12'h3E2;
    endfunction

    function automatic logic [11:0] m_code_col(input int c);
        if (c == 0) return 12'hFFF;
        if (c == 3) return connected ? 12'h567 : 12'h123;
        if (c >= 4 && c < 4 + N_BTN) return m_btn_col(m_ph[c-4]);
        return 12'h000;
    endfunction

    // Advance the model with the inputs now applied, then clock the DUT once
    task automatic step();
        int  next_rom;
        bit  edge_seen, hov;
        next_rom = rom_fn(m_addr);
        if (rst) begin
            m_pix = 12'h000; m_addr = 0; m_mlq = 1'b1; m_click = '0;
            for (int i = 0; i <= ROM_LAT; i++) m_v[i] = 1'b0;
            for (int k = 0; k < N_BTN; k++) begin m_ph[k] = 0; m_fl[k] = 0; end
        end else begin
            m_pix  = m_v[ROM_LAT] ? m_code_col(m_rom) : 12'h000;
            m_addr = ((int'(h_cnt) >> SCALE) + IMG_W * (int'(v_cnt) >> SCALE)) % DEPTH;
            for (int i = ROM_LAT; i > 0; i--) m_v[i] = m_v[i-1];
            m_v[0]    = valid;
            edge_seen = mouse_left && !m_mlq;
            m_mlq     = mouse_left;
            for (int k = 0; k < N_BTN; k++) begin
                hov        = mouse_on_btn && (int'(mouse_btn_id) == k);
                m_click[k] = 1'b0;
                case (m_ph[k])
                    0: if (hov) m_ph[k] = 1;
                    1: if (!hov) m_ph[k] = 0; else if (edge_seen) m_ph[k] = 2;
                    2: if (!hov) m_ph[k] = 0;
                       else if (!mouse_left) begin m_ph[k] = 3; m_fl[k] = FLASH_CYC - 1; m_click[k] = 1'b1; end
                    default: if (m_fl[k] == 0) m_ph[k] = hov ? 1 : 0; else m_fl[k]--;
                endcase
            end
        end
        m_rom = next_rom;
        @(posedge clka);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step(); step();
        n_cmp++; if (rom_bus.rom_addr !== 17'd0) begin n_bad++; $display("FAIL reset_addr: got %0d expected 0", rom_bus.rom_addr); end
        n_cmp++; if (pixel_out !== 12'h000) begin n_bad++; $display("FAIL reset_pixel: got %h expected 000", pixel_out); end
        n_cmp++; if (btn_click !== '0) begin n_bad++; $display("FAIL reset_click: got %b expected 0", btn_click); end
        rst = 1'b0;
    endtask

    task automatic test_addr_corners();
        h_cnt = 10'd639; v_cnt = 10'd479; step();
        n_cmp++; if (rom_bus.rom_addr !== 17'd76799) begin n_bad++; $display("FAIL addr_max: got %0d expected 76799", rom_bus.rom_addr); end
        h_cnt = 10'd0; v_cnt = 10'd0; step();
        n_cmp++; if (rom_bus.rom_addr !== 17'd0) begin n_bad++; $display("FAIL addr_zero: got %0d expected 0", rom_bus.rom_addr); end
        h_cnt = 10'd101; v_cnt = 10'd51; step();
        n_cmp++; if (rom_bus.rom_addr !== 17'd8050) begin n_bad++; $display("FAIL addr_mid: got %0d expected 8050", rom_bus.rom_addr); end
    endtask

    task automatic test_link_colour();
        force_code = 3; connected = 1'b0; valid = 1'b0;
        step(); step(); step();
        valid = 1'b1; h_cnt = 10'd20; v_cnt = 10'd30;
        step();
        n_cmp++; if (pixel_out !== 12'h000) begin n_bad++; $display("FAIL link_lat1: got %h expected 000", pixel_out); end
        step();
        n_cmp++; if (pixel_out !== 12'h000) begin n_bad++; $display("FAIL link_lat2: got %h expected 000", pixel_out); end
        step();
        n_cmp++; if (pixel_out !== 12'h123) begin n_bad++; $display("FAIL link_down: got %h expected 123", pixel_out); end
        connected = 1'b1; step();
        n_cmp++; if (pixel_out !== 12'h567) begin n_bad++; $display("FAIL link_up: got %h expected 567", pixel_out); end
        valid = 1'b0; step(); step(); step();
        n_cmp++; if (pixel_out !== 12'h000) begin n_bad++; $display("FAIL blank: got %h expected 000", pixel_out); end
    endtask

    task automatic test_click();
        int cnt;
        force_code = 6; valid = 1'b1; mouse_on_btn = 1'b0; mouse_left = 1'b0;
        step(); step(); step();
        n_cmp++; if (pixel_out !== 12'h000) begin n_bad++; $display("FAIL click_idle_pix: got %h expected 000", pixel_out); end
        mouse_on_btn = 1'b1; mouse_btn_id = 4'd2; step();
        mouse_left = 1'b1; step();
        mouse_left = 1'b0; step();
        n_cmp++; if (btn_click !== 4'b0100) begin n_bad++; $display("FAIL click_pulse: got %b expected 0100", btn_click); end
        step();
        n_cmp++; if (btn_click !== 4'b0000) begin n_bad++; $display("FAIL click_one_cycle: got %b expected 0000", btn_click); end
        cnt = 0;
        while (pixel_out === 12'h3E2 && cnt < 20) begin cnt++; step(); end
        n_cmp++; if (cnt != FLASH_CYC) begin n_bad++; $display("FAIL flash_len: got %0d expected %0d", cnt, FLASH_CYC); end
        n_cmp++; if (pixel_out !== 12'h32E) begin n_bad++; $display("FAIL flash_to_hover: got %h expected 32E", pixel_out); end
    endtask

    task automatic test_cancel();
        logic [N_BTN-1:0] seen;
        force_code = 5; mouse_on_btn = 1'b0; mouse_left = 1'b0;
        step(); step();
        seen = '0;
        mouse_on_btn = 1'b1; mouse_btn_id = 4'd1; step(); seen |= btn_click;
        mouse_left = 1'b1;   step(); seen |= btn_click;
        mouse_on_btn = 1'b0; step(); seen |= btn_click;
        mouse_left = 1'b0;   step(); seen |= btn_click;
        step(); seen |= btn_click;
        n_cmp++; if (seen !== '0) begin n_bad++; $display("FAIL cancel_click: got %b expected 0", seen); end
        n_cmp++; if (pixel_out !== 12'h000) begin n_bad++; $display("FAIL cancel_pix: got %h expected 000", pixel_out); end
        mouse_on_btn = 1'b1; step(); step();
        n_cmp++; if (pixel_out !== 12'h32E) begin n_bad++; $display("FAIL cancel_rehover: got %h expected 32E", pixel_out); end
        mouse_on_btn = 1'b0; step();
    endtask

    task automatic test_held_entry();
        logic [N_BTN-1:0] seen;
        force_code = 4; mouse_on_btn = 1'b0; mouse_left = 1'b1;
        step(); step();
        seen = '0;
        mouse_on_btn = 1'b1; mouse_btn_id = 4'd0; step(); seen |= btn_click;
        step(); seen |= btn_click;
        mouse_left = 1'b0; step(); seen |= btn_click;
        step(); seen |= btn_click;
        n_cmp++; if (seen !== '0) begin n_bad++; $display("FAIL held_click: got %b expected 0", seen); end
        n_cmp++; if (pixel_out !== 12'h32E) begin n_bad++; $display("FAIL held_pix: got %h expected 32E", pixel_out); end
        mouse_btn_id = 4'd13; step(); step(); seen |= btn_click;
        n_cmp++; if (pixel_out !== 12'h000) begin n_bad++; $display("FAIL id13_pix: got %h expected 000", pixel_out); end
        mouse_left = 1'b1; step(); seen |= btn_click;
        mouse_left = 1'b0; step(); seen |= btn_click; step(); seen |= btn_click;
        n_cmp++; if (seen !== '0) begin n_bad++; $display("FAIL id13_click: got %b expected 0", seen); end
        mouse_on_btn = 1'b0;
    endtask

    task automatic test_reset_flash();
        logic [N_BTN-1:0] seen;
        force_code = 7; mouse_on_btn = 1'b1; mouse_btn_id = 4'd3; mouse_left = 1'b0;
        step(); step();
        mouse_left = 1'b1; step();
        mouse_left = 1'b0; step();
        n_cmp++; if (btn_click !== 4'b1000) begin n_bad++; $display("FAIL rf_click: got %b expected 1000", btn_click); end
        step(); step();
        mouse_on_btn = 1'b0; rst = 1'b1; step();
        n_cmp++; if (btn_click !== '0) begin n_bad++; $display("FAIL rf_click_clr: got %b expected 0", btn_click); end
        n_cmp++; if (pixel_out !== 12'h000) begin n_bad++; $display("FAIL rf_pix: got %h expected 000", pixel_out); end
        rst = 1'b0; seen = '0;
        for (int i = 0; i < 4; i++) begin step(); seen |= btn_click; end
        n_cmp++; if (pixel_out !== 12'h000) begin n_bad++; $display("FAIL rf_idle_pix: got %h expected 000", pixel_out); end
        n_cmp++; if (seen !== '0) begin n_bad++; $display("FAIL rf_no_click: got %b expected 0", seen); end
    endtask

    task automatic test_random();
        force_code = -1;
        for (int c = 0; c < 3000; c++) begin
            h_cnt = 10'($urandom_range(0, 639));
            v_cnt = 10'($urandom_range(0, 479));
            valid = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 7) == 0) begin
                mouse_on_btn = 1'($urandom_range(0, 1));
                mouse_btn_id = ($urandom_range(0, 5) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, N_BTN));
            end
            if ($urandom_range(0, 3) == 0) mouse_left = ~mouse_left;
            if ($urandom_range(0, 63) == 0) connected = ~connected;
            rst = ($urandom_range(0, 299) == 0);
            step();
            n_cmp++; if (rom_bus.rom_addr !== 17'(m_addr)) begin n_bad++; $display("FAIL rnd_addr @%0d: got %0d expected %0d", c, rom_bus.rom_addr, m_addr); end
            n_cmp++; if (pixel_out !== m_pix) begin n_bad++; $display("FAIL rnd_pix @%0d: got %h expected %h", c, pixel_out, m_pix); end
            n_cmp++; if (btn_click !== m_click) begin n_bad++; $display("FAIL rnd_click @%0d: got %b expected %b", c, btn_click, m_click); end
        end
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; h_cnt = '0; v_cnt = '0; valid = 1'b0; mouse_left = 1'b0;
        mouse_on_btn = 1'b0; mouse_btn_id = '0; connected = 1'b0;
        test_reset();
        test_addr_corners();
        test_link_colour();
        test_click();
        test_cancel();
        test_held_entry();
        test_reset_flash();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/menu_button_pixel_gen.md
MENU_BUTTON_PIXEL_GEN -- requirements
Module: menu_button_pixel_gen

Interface
REQ-001 Parameters SHALL be (name, default, meaning): N_BTN, 4, number of menu buttons (1..12); SCALE, 1, pixel-doubling shift; IMG_W, 320, ROM image width; DEPTH, 76800, ROM words; ROM_LAT, 1, ROM read latency in cycles; FLASH_CYC, 8, click-flash duration in cycles.
REQ-002 Ports SHALL be (name, direction, width, meaning):
 clka  in  1  sole clock
 rst  in  1  synchronous active-high reset
 h_cnt  in  10  horizontal pixel counter
 v_cnt  in  10  vertical pixel counter
 valid  in  1  active video
 mouse_left  in  1  left mouse button level
 mouse_on_btn  in  1  cursor inside some button
 mouse_btn_id  in  4  index of that button
 connected  in  1  link status
 rom_addr  out  17  ROM read address
 rom_data  in  4  ROM colour code
 pixel_out  out  12  RGB444 pixel
 btn_click  out  N_BTN  one-cycle click pulse per button
REQ-003 Clock SHALL be clka; reset SHALL be rst, synchronous, active-high.

Function
REQ-004 rom_addr SHALL be registered: ((h_cnt>>SCALE) + IMG_W*(v_cnt>>SCALE)) mod DEPTH.
REQ-005 valid SHALL be delayed ROM_LAT+1 cycles to align with rom_data; pixel_out SHALL be registered, total latency h_cnt/v_cnt -> pixel_out = ROM_LAT+2 cycles.
REQ-006 Code map: 0 -> 12'hFFF; 1 -> 12'h000; 3 -> connected ? 12'h567 : 12'h123; 4+k (k<N_BTN) -> colour of button k; codes 2 and 4+N_BTN..15 -> 12'h000.
REQ-007 pixel_out SHALL be 12'h000 whenever aligned valid is 0.
REQ-008 hover[k] = mouse_on_btn && mouse_btn_id==k; ids >= N_BTN hover nothing.
REQ-009 mouse_left SHALL be registered once; press edge = mouse_left && !mouse_left_q.
REQ-010 Each button SHALL own a four-state FSM: IDLE, HOVER, PRESS, FLASH.
REQ-011 IDLE->HOVER when hover[k]; HOVER->IDLE when !hover[k].
REQ-012 HOVER->PRESS on press edge while hover[k]; press entering with button already held SHALL NOT arm.
REQ-013 PRESS->FLASH when !mouse_left && hover[k], asserting btn_click[k] for exactly that cycle and loading flash counter with FLASH_CYC-1.
REQ-014 PRESS->IDLE when !hover[k] (cancelled, no click), regardless of mouse_left.
REQ-015 FLASH SHALL decrement each cycle and exit at 0 to HOVER if hover[k] else IDLE; press edges during FLASH SHALL be ignored.
REQ-016 Button colour: IDLE 12'h000, HOVER 12'h32E, PRESS and FLASH 12'h3E2.
REQ-017 FSM state and colour selection SHALL use current state (no extra alignment with pixel pipeline).
REQ-018 At most one button SHALL be non-IDLE-from-hover at a time; FLASH of a left button may overlap HOVER of another.

Reset
REQ-019 rst SHALL set rom_addr=0, pixel_out=12'h000, btn_click=0, all FSMs IDLE, flash counters 0, valid pipeline 0, mouse_left_q=1.
REQ-020 rst asserted mid-PRESS or mid-FLASH SHALL return to IDLE with no click pulse.

Structure
REQ-021 Colour constants, code values and the FSM state enum SHALL live in shared package menu_pkg.
REQ-022 Per-button FSM plus flash counter SHALL be sub-module menu_btn_fsm, generated N_BTN times.
REQ-023 The ROM SHALL be external to this block.

Verification
REQ-024 h_cnt=639,v_cnt=479,SCALE=1 -> rom_addr=76799 one cycle later; h_cnt=0,v_cnt=0 -> 0.
REQ-025 ROM model returning 3, connected toggled 0->1, ROM_LAT=1 -> pixel_out 12'h123 then 12'h567, three cycles after address.
REQ-026 Hover btn 2, press, release while hovering -> btn_click=4'b0100 one cycle, code 6 pixels 12'h3E2 for FLASH_CYC cycles, then 12'h32E.
REQ-027 Hover btn 1, press, move off, release -> no btn_click, FSM IDLE, code 5 pixels 12'h000.
REQ-028 Enter btn 0 with mouse_left already 1, release -> no click; mouse_btn_id=13 -> no hover.
REQ-029 rst during FLASH of btn 3 -> next cycle IDLE, btn_click=0, pixel_out=12'h000.
